// File: rtl/mapped_spiram_burst.sv
// Memory-mapped SPI RAM bridge: 32-bit word reads/writes translated to SPI mode-0 transactions.
// Optional macro SPIRAM_FAST_READ_EN selects fast read (0x0B) with 8 dummy clocks.
module mapped_spiram_burst #(
    parameter int CLK_DIV    = 27,
    parameter int ADDR_BYTES = 3,
    parameter int CS_GAP     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [21:0] word_address,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [31:0] rdata,
    output logic        rbusy,
    output logic        wbusy,
    output logic        sclk,
    output logic        cs_n,
    output logic        mosi,
    input  logic        miso
);

    typedef enum logic [2:0] {IDLE, CMD, DUMMY, DATA, GAP} state_t;

    localparam int          CMD_BITS = 8 + 8 * ADDR_BYTES;
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0]  GAP_LAST = 4'(CS_GAP - 1);
    localparam logic [5:0]  CMD_LAST = 6'(CMD_BITS - 1);
    localparam logic [7:0]  WR_OP    = 8'h02;
`ifdef SPIRAM_FAST_READ_EN
    localparam logic [7:0]  RD_OP    = 8'h0B;
`else
    localparam logic [7:0]  RD_OP    = 8'h03;
`endif

    state_t      state;
    logic [7:0]  div_cnt;
    logic [3:0]  gap_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;
    logic        rx_done;
    logic        is_read;
    logic        burst;
    logic [3:0]  pend_mask;
    logic [1:0]  cur_idx;
    logic [31:0] wdata_q;
    logic [21:0] addr_q;

    // Command word is left-aligned so shifting always starts at bit 31.
    function automatic logic [31:0] cmd_word(input logic [7:0] op, input logic [23:0] ba);
        if (ADDR_BYTES == 3) return {op, ba};
        else                 return {op, ba[15:0], 8'h00};
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [1:0] first_bit(input logic [3:0] m);
        casez (m)
            4'b???1: return 2'd0;
            4'b??10: return 2'd1;
            4'b?100: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic [1:0]  idle_idx, gap_idx;
    logic [31:0] start_cmd, gap_cmd, wdata_word;

    always_comb begin
        idle_idx   = first_bit(wmask);
        gap_idx    = first_bit(pend_mask);
        start_cmd  = cmd_word(RD_OP, {word_address, 2'b00});
        if (!rd) begin
            if (wmask == 4'hF) start_cmd = cmd_word(WR_OP, {word_address, 2'b00});
            else               start_cmd = cmd_word(WR_OP, {word_address, idle_idx});
        end
        gap_cmd    = cmd_word(WR_OP, {addr_q, gap_idx});
        wdata_word = burst ? swap32(wdata_q) : {wdata_q[8*cur_idx +: 8], 24'h0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cs_n      <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            rbusy     <= 1'b0;
            wbusy     <= 1'b0;
            rdata     <= '0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_done   <= 1'b0;
            is_read   <= 1'b0;
            burst     <= 1'b0;
            pend_mask <= '0;
            cur_idx   <= '0;
            wdata_q   <= '0;
            addr_q    <= '0;
        end else begin
            // Read data lands one clk after the final sampling edge, mid high phase.
            if (rx_done) begin
                rdata   <= swap32(rx_sr);
                rbusy   <= 1'b0;
                rx_done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b0;
                    mosi <= 1'b0;
                    if (rd || (wr && wmask != 4'h0)) begin
                        state   <= CMD;
                        cs_n    <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= CMD_LAST;
                        tx_sr   <= start_cmd;
                        mosi    <= start_cmd[31];
                        is_read <= rd;
                        addr_q  <= word_address;
                        wdata_q <= wdata;
                        if (rd) begin
                            rbusy <= 1'b1;
                        end else begin
                            wbusy     <= 1'b1;
                            burst     <= (wmask == 4'hF);
                            cur_idx   <= idle_idx;
                            pend_mask <= (wmask == 4'hF) ? 4'h0 : (wmask & ~(4'b0001 << idle_idx));
                        end
                    end
                end
                GAP: begin
                    cs_n <= 1'b1;
                    sclk <= 1'b0;
                    mosi <= 1'b0;
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end else if (pend_mask != 4'h0) begin
                        state     <= CMD;
                        cs_n      <= 1'b0;
                        div_cnt   <= '0;
                        bit_cnt   <= CMD_LAST;
                        tx_sr     <= gap_cmd;
                        mosi      <= gap_cmd[31];
                        cur_idx   <= gap_idx;
                        pend_mask <= pend_mask & ~(4'b0001 << gap_idx);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                            if (state == DATA && is_read) begin
                                rx_sr <= {rx_sr[30:0], miso};
                                if (bit_cnt == 6'd0) rx_done <= 1'b1;
                            end
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt != 6'd0) begin
                                bit_cnt <= bit_cnt - 6'd1;
                                tx_sr   <= {tx_sr[30:0], 1'b0};
                                mosi    <= tx_sr[30];
                            end else if (state == CMD) begin
                                if (is_read) begin
`ifdef SPIRAM_FAST_READ_EN
                                    state   <= DUMMY;
                                    bit_cnt <= 6'd7;
`else
                                    state   <= DATA;
                                    bit_cnt <= 6'd31;
`endif
                                    tx_sr   <= '0;
                                    mosi    <= 1'b0;
                                end else begin
                                    state   <= DATA;
                                    bit_cnt <= burst ? 6'd31 : 6'd7;
                                    tx_sr   <= wdata_word;
                                    mosi    <= wdata_word[31];
                                end
`ifdef SPIRAM_FAST_READ_EN
                            end else if (state == DUMMY) begin
                                state   <= DATA;
                                bit_cnt <= 6'd31;
                                tx_sr   <= '0;
                                mosi    <= 1'b0;
`endif
                            end else begin
                                state   <= GAP;
                                cs_n    <= 1'b1;
                                mosi    <= 1'b0;
                                gap_cnt <= '0;
                                if (!is_read && pend_mask == 4'h0) wbusy <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mapped_spiram_burst.sv
// Directed bench for mapped_spiram_burst with a behavioural SPI RAM slave that logs MOSI frames.
module tb_mapped_spiram_burst;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 4;
`ifdef SPIRAM_FAST_READ_EN
    localparam int          ROFF  = 40;
    localparam logic [7:0]  RD_OP = 8'h0B;
`else
    localparam int          ROFF  = 32;
    localparam logic [7:0]  RD_OP = 8'h03;
`endif
    localparam int RBUSY_EXP = 256 + (ROFF - 32) * 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0, wr = 1'b0;
    logic [21:0] word_address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] rdata;
    logic        rbusy, wbusy, sclk, cs_n, mosi, miso;

    mapped_spiram_burst #(.CLK_DIV(CLK_DIV), .ADDR_BYTES(3), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .word_address(word_address),
        .wdata(wdata), .wmask(wmask), .rdata(rdata), .rbusy(rbusy), .wbusy(wbusy),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // SPI slave model: logs MOSI per frame, returns rdat_m bits during the data phase.
    logic [127:0] cur = '0;
    int           len = 0, bit_idx = 0, ntx = 0;
    logic [127:0] txq [16];
    int           txlen [16];
    logic [31:0]  rdat_m = '0;
    int           hi_cnt = 0, last_gap = 0, busy_cnt = 0;
    logic         wbusy_seen = 1'b0;

    function automatic logic miso_bit(input int idx, input logic [31:0] d);
        if (idx >= ROFF && idx < ROFF + 32) return d[31 - (idx - ROFF)];
        return 1'b0;
    endfunction
    assign miso = miso_bit(bit_idx, rdat_m);

    always @(posedge sclk) if (cs_n === 1'b0) begin
        cur = {cur[126:0], mosi};
        len++;
        bit_idx++;
    end
    always @(negedge cs_n) begin
        cur = '0; len = 0; bit_idx = 0;
        last_gap = hi_cnt; hi_cnt = 0;
    end
    always @(posedge cs_n) if (len > 0) begin
        txq[ntx] = cur; txlen[ntx] = len;
        if (ntx < 15) ntx++;
    end
    always @(posedge clk) begin
        if (cs_n === 1'b1) hi_cnt++;
        if (rbusy === 1'b1) busy_cnt++;
        if (wbusy === 1'b1) wbusy_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((rbusy !== 1'b0 || wbusy !== 1'b0 || cs_n !== 1'b1) && n < 3000) begin
            tick(1);
            n++;
        end
        chk(tag, 64'(n < 3000), 64'd1);
        tick(CS_GAP + 4);
    endtask

    initial begin
        int base;
        tick(3);
        chk("reset_cs_n", 64'(cs_n), 64'd1);
        chk("reset_sclk", 64'(sclk), 64'd0);
        chk("reset_mosi", 64'(mosi), 64'd0);
        chk("reset_rbusy", 64'(rbusy), 64'd0);
        chk("reset_wbusy", 64'(wbusy), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        reset = 1'b0;
        tick(2);

        // Read at word 0x10 -> byte address 0x40
        base = ntx; rdat_m = 32'h11223344; busy_cnt = 0;
        word_address = 22'h10; rd = 1'b1;
        tick(1); rd = 1'b0;
        chk("rd_accept_rbusy", 64'(rbusy), 64'd1);
        chk("rd_accept_cs_n", 64'(cs_n), 64'd0);
        wait_idle("rd_timeout");
        chk("rd_rdata", 64'(rdata), 64'h44332211);
        checks++;
        assert (busy_cnt >= RBUSY_EXP - 2 && busy_cnt <= RBUSY_EXP + 2) else begin
            failures++;
            $error("FAIL rd_rbusy_len observed=%0d expected=%0d+/-2", busy_cnt, RBUSY_EXP);
        end
        chk("rd_frames", 64'(ntx - base), 64'd1);
        chk("rd_len", 64'(txlen[base]), 64'(ROFF + 32));
        chk("rd_cmd", 64'(txq[base][ROFF + 31 -: 32]), {32'h0, RD_OP, 24'h000040});

        // Burst write
        base = ntx; wbusy_seen = 1'b0;
        word_address = 22'h4; wdata = 32'hA1B2C3D4; wmask = 4'hF; wr = 1'b1;
        tick(1); wr = 1'b0;
        chk("wrb_accept_wbusy", 64'(wbusy), 64'd1);
        wait_idle("wrb_timeout");
        chk("wrb_frames", 64'(ntx - base), 64'd1);
        chk("wrb_len", 64'(txlen[base]), 64'd64);
        chk("wrb_bits", txq[base][63:0], 64'h02000010D4C3B2A1);

        // Partial write, mask 1010
        base = ntx;
        word_address = 22'h0; wmask = 4'b1010; wr = 1'b1;
        tick(1); wr = 1'b0;
        wait_idle("wrp_timeout");
        chk("wrp_frames", 64'(ntx - base), 64'd2);
        chk("wrp_len0", 64'(txlen[base]), 64'd40);
        chk("wrp_bits0", {24'h0, txq[base][39:0]}, 64'h02000001C3);
        chk("wrp_len1", 64'(txlen[base + 1]), 64'd40);
        chk("wrp_bits1", {24'h0, txq[base + 1][39:0]}, 64'h02000003A1);
        chk("wrp_gap_ok", 64'(last_gap >= CS_GAP), 64'd1);

        // Zero mask write is ignored
        base = ntx; wbusy_seen = 1'b0;
        wmask = 4'h0; wr = 1'b1;
        tick(1); wr = 1'b0;
        tick(20);
        chk("wr0_wbusy", 64'(wbusy_seen), 64'd0);
        chk("wr0_frames", 64'(ntx - base), 64'd0);
        chk("wr0_cs_n", 64'(cs_n), 64'd1);

        // rd+wr together, then wr during the read
        base = ntx; wbusy_seen = 1'b0; rdat_m = 32'h55667788;
        word_address = 22'h20; wmask = 4'hF; rd = 1'b1; wr = 1'b1;
        tick(1); rd = 1'b0; wr = 1'b0;
        tick(30); wr = 1'b1;
        tick(1); wr = 1'b0;
        wait_idle("rdwr_timeout");
        chk("rdwr_wbusy", 64'(wbusy_seen), 64'd0);
        chk("rdwr_frames", 64'(ntx - base), 64'd1);
        chk("rdwr_rdata", 64'(rdata), 64'h88776655);
        chk("rdwr_cmd", 64'(txq[base][ROFF + 31 -: 32]), {32'h0, RD_OP, 24'h000080});

        // Reset 50 cycles into a read
        rdat_m = 32'h01020304; word_address = 22'h10; rd = 1'b1;
        tick(1); rd = 1'b0;
        tick(49); reset = 1'b1;
        tick(1);
        chk("rst_mid_cs_n", 64'(cs_n), 64'd1);
        chk("rst_mid_rbusy", 64'(rbusy), 64'd0);
        chk("rst_mid_rdata", 64'(rdata), 64'd0);
        reset = 1'b0;
        tick(CS_GAP + 2);
        base = ntx; rdat_m = 32'hDEADBEEF;
        rd = 1'b1;
        tick(1); rd = 1'b0;
        wait_idle("rst_rd_timeout");
        chk("rst_rd_rdata", 64'(rdata), 64'hEFBEADDE);
        chk("rst_rd_len", 64'(txlen[base]), 64'(ROFF + 32));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
